m_serial_rx_os16: RTL
=====================

Name: m_serial_rx_os16

Overview:
- 16x-oversampling UART receiver; the receiving end for the 8N1 serial transmitter.
- Runs entirely in the system `clk` domain and needs no derived serial clock.
- Mid-bit sampling with start-bit glitch rejection; stop-bit check with framing-error report.
- Delivers each received byte with a one-cycle `valid` strobe to downstream logic (7-seg display, loopback, etc.).

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 9600, line bit rate.
- OS, 16, oversampling ticks per bit; must be even and at least 4.
- DIV, CLK_HZ/(BAUD*OS), clocks per oversample tick (integer, truncated); must be at least 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- sin  input  1  asynchronous serial line; idles high.
- dat  output 8  last correctly received byte.
- valid  output 1  one-clk pulse; `dat` holds a new byte.
- frame_err  output 1  one-clk pulse; stop bit sampled low.
- parity_err  output 1  one-clk pulse; parity mismatch (tied 0 unless `PARITY_EN` is defined).
- busy  output 1  high in every state except IDLE.

Behaviour:
- Reset values:
  - `dat` = 8'h00; `valid`, `frame_err`, `parity_err`, `busy` = 0.
  - State = IDLE; prescaler, tick and bit counters = 0.
  - Both synchronizer flops = 1.
- `sin` passes through a 2-flop synchronizer (`s_sin`). All decisions use `s_sin`, which adds 2 clocks of latency.
- Prescaler counts 0..DIV-1; `tick` is true when it equals DIV-1, then it wraps to 0. It is forced to 0 whenever the FSM is in IDLE.
- Tick counter `tc` counts 0..OS-1 on each `tick`.
- State IDLE:
  - On `s_sin`==0, go to START with `tc`=0 and prescaler=0.
- State START:
  - On the tick where `tc`==OS/2-1 (bit centre):
    - If `s_sin`==0, go to DATA with `tc`=0 and bit count = 0.
    - If `s_sin`==1, the start was a glitch: return to IDLE with no output pulse.
- State DATA:
  - On each tick where `tc`==OS-1, sample `s_sin` and shift it in LSB-first: `sreg` <= {`s_sin`, `sreg`[7:1]}.
  - Increment the bit count after each sample.
  - After the 8th sample, go to PARITY if `PARITY_EN` is defined, otherwise go to STOP; `tc`=0.
- State STOP:
  - On the tick where `tc`==OS-1, sample the stop bit.
  - If 1: `dat` <= `sreg`, pulse `valid` for exactly 1 clk, go to IDLE.
  - If 0: pulse `frame_err` for 1 clk, leave `dat` unchanged, go to BREAK.
- State BREAK:
  - Remain until `s_sin`==1, then go to IDLE.
  - A held-low line therefore yields exactly one `frame_err` and no bytes.
- Return to IDLE happens at mid stop bit, so a back-to-back start bit is caught with up to half a bit of tolerance.
- `valid` and `frame_err` are never asserted in the same cycle.
- `dat` changes only in the cycle `valid` is asserted.
- Latency: `valid` rises 2 (sync) + 9.5 bit times ±1 tick after the `sin` falling edge, or 10.5 bit times with parity.
- `rst` asserted mid-frame aborts immediately to reset values. After `rst` deasserts, a line that is low is treated as a start bit.
- Counter widths are sized with $clog2 from DIV and OS; no counter ever exceeds its terminal value.

Optional Feature:
- Macro `PARITY_EN`.
- When defined:
  - The FSM inserts state PARITY between DATA and STOP.
  - On the tick where `tc`==OS-1, the parity bit is sampled.
  - Parity is even: the XOR of the 8 data bits and the parity bit must be 0.
  - On mismatch, set an internal flag. At the STOP sample, if the stop bit is 1 and the flag is set, pulse `parity_err` instead of `valid` and leave `dat` unchanged.
  - A framing error takes priority over a parity error.
- When not defined:
  - There is no PARITY state; the frame is 10 bits.
  - `parity_err` is constantly 0.

Test Plan:
- Bench parameters: CLK_HZ=1600000, BAUD=10000, OS=16, giving DIV=10 and 160 clk/bit.
- Reset then idle: `sin`=1 for 2000 clk -> `valid`=`frame_err`=`busy`=0, `dat`=8'h00.
- Send frame 0x55, then 0xA3 back-to-back (no idle gap) -> two `valid` pulses, each 1 clk wide; `dat`=8'h55 then 8'hA3; first pulse 1522±16 clk after the start edge.
- Glitch: `sin` low for 40 clk, then high -> no pulse; `busy` returns to 0 within 82 clk of the edge.
- Stop bit forced low on 0x3C, then line held low 3000 clk, then high, then send 0x7E -> single `frame_err` pulse; `dat` keeps its previous value; then `valid` with `dat`=8'h7E.
- Frame rate offset: send 0x81 at +3% and -3% baud -> `dat`=8'h81 and `valid` in both cases.
- With `PARITY_EN`:
  - 0x0F with parity bit 0 -> `valid`, `dat`=8'h0F.
  - 0x0F with parity bit 1 -> `parity_err` pulse, no `valid`.
  - `rst` pulsed at data bit 4 -> all outputs 0 next clk, the partial byte is discarded, and the next frame 0x11 is received correctly.

Source files
------------

// File: rtl/m_serial_rx_os16.sv
`default_nettype none
// ============================================================================
// m_serial_rx_os16 : 16x-oversampled 8N1 UART receiver, mid-bit sampling,
// glitch-rejecting start, framing error strobe; `PARITY_EN adds even parity.
// Revision: 1.0
// ============================================================================
module m_serial_rx_os16 #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 9600,
  parameter int OS     = 16,
  parameter int DIV    = CLK_HZ / (BAUD * OS)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sin,
  output logic [7:0] dat,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW = $clog2(OS);
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [TW-1:0] T_MID  = TW'(OS / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    BREAK  = 3'd4
`ifdef PARITY_EN
    , PARITY = 3'd5
`endif
  } state_t;

  state_t        state, state_n;
  logic          sync1, s_sin;
  logic [PW-1:0] presc;
  logic [TW-1:0] tc, tc_n;
  logic [3:0]    bc, bc_n;
  logic [7:0]    sreg, sreg_n, dat_n;
  logic          valid_n, ferr_n;
  logic          tick;

`ifdef PARITY_EN
  logic pflag, pflag_n, perr_n;
`endif

  assign tick = (state != IDLE) && (presc == P_LAST);
  assign busy = (state != IDLE);

  always_comb begin
    state_n = state;
    tc_n    = tc;
    bc_n    = bc;
    sreg_n  = sreg;
    dat_n   = dat;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
`ifdef PARITY_EN
    pflag_n = pflag;
    perr_n  = 1'b0;
`endif
    if (tick) tc_n = (tc == T_LAST) ? '0 : tc + 1'b1;

    case (state)
      IDLE: begin
        tc_n = '0;
        if (!s_sin) state_n = START;
      end
      START: begin
        if (tick && tc == T_MID) begin
          tc_n    = '0;
          bc_n    = 4'd0;
          state_n = s_sin ? IDLE : DATA;
`ifdef PARITY_EN
          pflag_n = 1'b0;
`endif
        end
      end
      DATA: begin
        if (tick && tc == T_LAST) begin
          sreg_n = {s_sin, sreg[7:1]};
          bc_n   = bc + 4'd1;
          tc_n   = '0;
          if (bc == 4'd7) begin
`ifdef PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (tick && tc == T_LAST) begin
          tc_n    = '0;
          pflag_n = ^{s_sin, sreg};
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (tick && tc == T_LAST) begin
          tc_n = '0;
          if (s_sin) begin
            state_n = IDLE;
`ifdef PARITY_EN
            if (pflag) begin
              perr_n = 1'b1;
            end else begin
              dat_n   = sreg;
              valid_n = 1'b1;
            end
`else
            dat_n   = sreg;
            valid_n = 1'b1;
`endif
          end else begin
            ferr_n  = 1'b1;
            state_n = BREAK;
          end
        end
      end
      BREAK: begin
        // A held-low line stays here so it reports only one framing error.
        tc_n = '0;
        if (s_sin) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b1;
      s_sin     <= 1'b1;
      state     <= IDLE;
      presc     <= '0;
      tc        <= '0;
      bc        <= 4'd0;
      sreg      <= 8'h00;
      dat       <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync1     <= sin;
      s_sin     <= sync1;
      state     <= state_n;
      presc     <= (state == IDLE || tick) ? '0 : presc + 1'b1;
      tc        <= tc_n;
      bc        <= bc_n;
      sreg      <= sreg_n;
      dat       <= dat_n;
      valid     <= valid_n;
      frame_err <= ferr_n;
    end
  end

`ifdef PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pflag      <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      pflag      <= pflag_n;
      parity_err <= perr_n;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire
